rr_write_arbiter: RTL and testbench
===================================

# rr_write_arbiter

Round-robin write arbiter sharing one FIFO write port among `NUM_WRITERS` independent writers. Each writer presents a byte and a request; the block selects one requester per cycle, releases it through its busy line, and drives a registered valid/data stage into the FIFO. It honours FIFO backpressure without losing or duplicating data. It sits between the writer modules and the shared FIFO, replacing direct writer-to-FIFO connections.

## Interface
- `NUM_WRITERS`, default 2: number of writers; legal range 2..8.
- `GW`, default `$clog2(NUM_WRITERS)`: grant index width (derived, not overridden).

Ports:
- `i_clk` input 1: clock; all state on rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_data` input 8*NUM_WRITERS: writer n's byte on bits [8n+7:8n].
- `i_req` input NUM_WRITERS: writer n has a byte to write; held with data until released.
- `o_busy` output NUM_WRITERS: 1 = writer must hold data; 0 for one cycle = byte accepted.
- `i_full` input 1: FIFO cannot accept this cycle.
- `o_we` output 1: output byte valid / FIFO write strobe; FIFO writes on an edge where `o_we && !i_full`.
- `o_data` output 8: byte to FIFO.
- `o_grant` output GW: index of writer whose byte is in `o_data`.

## Operation
- Output stage is a single register: `o_we`, `o_data`, `o_grant`.
  - `load = !o_we || !i_full`: stage empty or draining this edge.
- Eligibility:
  - `elig[n] = i_req[n] && o_busy[n]`.
  - A writer released on the previous edge (`o_busy[n]==0`) is ineligible for exactly one cycle.
- Selection is round-robin.
  - Search starts at `last+1` and wraps modulo NUM_WRITERS.
  - First eligible writer wins.
  - `last` updates to the winner only on a load.
  - After reset, `last = NUM_WRITERS-1`, so writer 0 has first priority.
- On an edge with `load` and a winner g:
  - `o_data <= i_data[8g+:8]`, `o_grant <= g`, `o_we <= 1`.
  - `o_busy[g] <= 0`; all other bits `<= 1`.
- On an edge with `load` and no winner:
  - `o_we <= 0`; `o_data` and `o_grant` hold.
  - `o_busy <=` all ones.
- On an edge with `!load` (stalled):
  - Output stage holds.
  - `o_busy <=` all ones; no writer is released.
- Invariant: at most one `o_busy` bit is 0 in any cycle.
- Writers see `o_busy[n]==0` for one cycle. They may then change data or drop `i_req[n]` before the next edge.
- A writer dropping `i_req` while busy is legal. It simply is not selected; no data is taken.

## Timing
- Reset (async assert, sync release) values:
  - `o_busy` = all ones, `o_we` = 0, `o_data` = 0, `o_grant` = 0, `last` = NUM_WRITERS-1.
  - A byte pending in the output stage is discarded.
- Latency: request sampled at edge k → `o_we`=1 with its data and `o_busy[g]`=0 during cycle k..k+1.
  - With `i_full`=0, the FIFO writes at edge k+1.
- Throughput:
  - Aggregate 1 byte/cycle with two or more active writers.
  - A single writer gets 1 byte per 2 cycles, because of the ineligible cycle.
- Backpressure: while `o_we && i_full`, data is held stable. When `i_full` drops, the write and the next load happen on the same edge.
- Simultaneous requests: strict round-robin. No writer waits more than NUM_WRITERS-1 grants while continuously requesting and not stalled.
- `i_full` changing while `o_we`=0 has no effect on loading.

## Test plan
- Reset: assert `i_reset` mid-transfer with `o_we`=1, `i_full`=1 → immediately `o_busy`=2'b11, `o_we`=0. After release, first grant goes to writer 0 when both request.
- Single writer, NUM_WRITERS=2: writer 0 holds `i_req`=1, sends 0x11 then 0x22, `i_full`=0 → `o_we` pattern 1,0,1. FIFO receives 0x11, 0x22. `o_busy[0]` pulses low each write cycle.
- Contention: both request continuously with data 0xA0 (w0) and 0xB1 (w1) → `o_grant` alternates 0,1,0,1. `o_we` is high every cycle. Never both busy bits low.
- Backpressure: `o_we`=1 with 0x5A, then `i_full`=1 for 3 cycles → `o_data` stays 0x5A and all busy bits stay 1. On `i_full`=0, the FIFO takes 0x5A and the next requester loads on the same edge.
- Fairness, NUM_WRITERS=4: all four request, with writer 2 last granted → grant order 3,0,1,2.
- Request withdrawal: writer 1 raises then drops `i_req` while stalled by `i_full`=1 → no byte from writer 1 appears. `o_busy[1]` never goes low.

Source files
------------

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter that funnels NUM_WRITERS byte writers into one FIFO write port
// through a single registered valid/data stage that honours FIFO backpressure.
module rr_write_arbiter #(
   parameter int unsigned NUM_WRITERS = 2,
   parameter int unsigned GW          = $clog2(NUM_WRITERS)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [8*NUM_WRITERS-1:0] i_data,
   input  logic [NUM_WRITERS-1:0]   i_req,
   output logic [NUM_WRITERS-1:0]   o_busy,
   input  logic                     i_full,
   output logic                     o_we,
   output logic [7:0]               o_data,
   output logic [GW-1:0]            o_grant
);

   localparam int unsigned DW = 8;

   logic [GW-1:0]          last;
   logic [NUM_WRITERS-1:0] elig_c;
   logic [NUM_WRITERS-1:0] busy_nxt_c;
   logic                   load_c;
   logic                   win_found_c;
   logic [GW-1:0]          win_idx_c;
   logic [GW-1:0]          cand_c;
   logic [DW-1:0]          win_data_c;

   // Stage can take a new byte when it is empty or being written this edge.
   assign load_c = !o_we || !i_full;

   // A writer released last cycle still shows busy low, so it sits out one cycle.
   assign elig_c = i_req & o_busy;

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      cand_c      = '0;
      for (int unsigned i = 1; i <= NUM_WRITERS; i++) begin
         cand_c = GW'((32'(last) + i) % NUM_WRITERS);
         if (!win_found_c && elig_c[cand_c]) begin
            win_found_c = 1'b1;
            win_idx_c   = cand_c;
         end
      end
   end

   always_comb begin
      win_data_c = '0;
      for (int unsigned n = 0; n < NUM_WRITERS; n++) begin
         if (win_idx_c == GW'(n)) begin
            win_data_c = i_data[DW*n +: DW];
         end
      end
   end

   // Only the writer loaded into the stage this edge is released.
   always_comb begin
      busy_nxt_c = '1;
      if (load_c && win_found_c) begin
         busy_nxt_c[win_idx_c] = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_busy  <= '1;
         o_we    <= 1'b0;
         o_data  <= '0;
         o_grant <= '0;
         last    <= GW'(NUM_WRITERS - 1);
      end else begin
         o_busy <= busy_nxt_c;
         if (load_c) begin
            if (win_found_c) begin
               o_we    <= 1'b1;
               o_data  <= win_data_c;
               o_grant <= win_idx_c;
               last    <= win_idx_c;
            end else begin
               o_we    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_write_arbiter.sv
// Bench for rr_write_arbiter: directed vector table on a 2-writer instance, hand sequences
// for reset and fairness, and randomized traffic on a 4-writer instance against a reference model.
module tb_rr_write_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2, full2, we2;
   logic [1:0]  req2, busy2;
   logic [15:0] data2;
   logic [7:0]  odata2;
   logic [0:0]  grant2;

   logic        rst4, full4, we4;
   logic [3:0]  req4, busy4;
   logic [31:0] data4;
   logic [7:0]  odata4;
   logic [1:0]  grant4;

   rr_write_arbiter #(.NUM_WRITERS(2)) dut2 (
      .i_clk(clk), .i_reset(rst2), .i_data(data2), .i_req(req2), .o_busy(busy2),
      .i_full(full2), .o_we(we2), .o_data(odata2), .o_grant(grant2));

   rr_write_arbiter #(.NUM_WRITERS(4)) dut4 (
      .i_clk(clk), .i_reset(rst4), .i_data(data4), .i_req(req4), .o_busy(busy4),
      .i_full(full4), .o_we(we4), .o_data(odata4), .o_grant(grant4));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [15:0] data;
      logic        full;
      logic        we;
      logic [7:0]  odata;
      logic        gnt;
      logic [1:0]  busy;
   } vec_t;

   vec_t tbl[19];

   // Reference model state for the 4-writer instance
   logic [3:0] m_busy, m_nb;
   logic       m_we, m_load;
   logic [7:0] m_data;
   int         m_grant, m_last, m_win, m_idx;

   initial begin
      // req, {w1,w0} data, full -> we, data, grant, busy
      tbl[0]  = '{2'b01, 16'h0011, 1'b0, 1'b1, 8'h11, 1'b0, 2'b10};
      tbl[1]  = '{2'b01, 16'h0022, 1'b0, 1'b0, 8'h11, 1'b0, 2'b11};
      tbl[2]  = '{2'b01, 16'h0022, 1'b0, 1'b1, 8'h22, 1'b0, 2'b10};
      tbl[3]  = '{2'b00, 16'h0022, 1'b0, 1'b0, 8'h22, 1'b0, 2'b11};
      tbl[4]  = '{2'b11, 16'hB1A0, 1'b0, 1'b1, 8'hB1, 1'b1, 2'b01};
      tbl[5]  = '{2'b11, 16'hB1A0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'b10};
      tbl[6]  = '{2'b11, 16'hB1A0, 1'b0, 1'b1, 8'hB1, 1'b1, 2'b01};
      tbl[7]  = '{2'b11, 16'hB1A0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'b10};
      tbl[8]  = '{2'b11, 16'hB1A0, 1'b1, 1'b1, 8'hA0, 1'b0, 2'b11};
      tbl[9]  = '{2'b11, 16'hB1A0, 1'b1, 1'b1, 8'hA0, 1'b0, 2'b11};
      tbl[10] = '{2'b11, 16'hB1A0, 1'b1, 1'b1, 8'hA0, 1'b0, 2'b11};
      tbl[11] = '{2'b11, 16'hB1A0, 1'b0, 1'b1, 8'hB1, 1'b1, 2'b01};
      tbl[12] = '{2'b00, 16'hB1A0, 1'b0, 1'b0, 8'hB1, 1'b1, 2'b11};
      tbl[13] = '{2'b01, 16'hB1A0, 1'b1, 1'b1, 8'hA0, 1'b0, 2'b10};
      tbl[14] = '{2'b00, 16'hB1A0, 1'b0, 1'b0, 8'hA0, 1'b0, 2'b11};
      tbl[15] = '{2'b01, 16'hB15A, 1'b0, 1'b1, 8'h5A, 1'b0, 2'b10};
      tbl[16] = '{2'b10, 16'hC75A, 1'b1, 1'b1, 8'h5A, 1'b0, 2'b11};
      tbl[17] = '{2'b00, 16'hC75A, 1'b1, 1'b1, 8'h5A, 1'b0, 2'b11};
      tbl[18] = '{2'b00, 16'hC75A, 1'b0, 1'b0, 8'h5A, 1'b0, 2'b11};

      rst2 = 1'b1; req2 = '0; data2 = '0; full2 = 1'b0;
      rst4 = 1'b1; req4 = '0; data4 = '0; full4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset2_state", {we2, odata2, grant2, busy2}, {1'b0, 8'h00, 1'b0, 2'b11});
      check("reset4_state", {we4, odata4, grant4, busy4}, {1'b0, 8'h00, 2'b00, 4'b1111});
      @(negedge clk);
      rst2 = 1'b0;
      rst4 = 1'b0;

      // Directed vectors on the 2-writer instance
      for (int i = 0; i < 19; i++) begin
         req2  = tbl[i].req;
         data2 = tbl[i].data;
         full2 = tbl[i].full;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), {we2, odata2, grant2, busy2},
               {tbl[i].we, tbl[i].odata, tbl[i].gnt, tbl[i].busy});
      end

      // Reset asserted mid-transfer while stalled
      req2 = 2'b11; data2 = 16'hB1A0; full2 = 1'b0;
      @(posedge clk);
      #1;
      check("pre_reset_we", 32'(we2), 32'd1);
      full2 = 1'b1;
      @(posedge clk);
      #2;
      rst2 = 1'b1;
      #1;
      check("async_reset", {we2, odata2, grant2, busy2}, {1'b0, 8'h00, 1'b0, 2'b11});
      @(negedge clk);
      rst2 = 1'b0;
      full2 = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_grant", {we2, odata2, grant2, busy2}, {1'b1, 8'hA0, 1'b0, 2'b10});

      // Fairness on 4 writers: make writer 2 the last winner, then all request
      req4 = 4'b0100; data4 = 32'h43424140;
      @(posedge clk);
      #1;
      check("fair_seed", {we4, odata4, grant4, busy4}, {1'b1, 8'h42, 2'd2, 4'b1011});
      req4 = 4'b1111;
      begin
         int order[4] = '{3, 0, 1, 2};
         for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("fair%0d", k), {we4, odata4, grant4},
                  {1'b1, 8'(8'h40 + order[k]), 2'(order[k])});
         end
      end

      // Randomized traffic on 4 writers against the reference model
      req4 = '0;
      rst4 = 1'b1;
      #1;
      rst4 = 1'b0;
      m_busy = 4'b1111; m_we = 1'b0; m_data = 8'h00; m_grant = 0; m_last = 3;
      @(negedge clk);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         full4 = ($urandom % 4) == 0;
         for (int n = 0; n < 4; n++) begin
            if (!req4[2'(n)] || !m_busy[2'(n)]) begin
               req4[2'(n)] = ($urandom % 10) < 7;
               data4[8*n +: 8] = 8'($urandom);
            end else if (($urandom % 20) == 0) begin
               req4[2'(n)] = 1'b0;
            end
         end
         m_load = !m_we || !full4;
         m_win = -1;
         for (int k = 1; k <= 4; k++) begin
            m_idx = (m_last + k) % 4;
            if (m_win < 0 && req4[2'(m_idx)] && m_busy[2'(m_idx)]) m_win = m_idx;
         end
         m_nb = 4'b1111;
         if (m_load) begin
            if (m_win >= 0) begin
               m_we = 1'b1;
               m_data = data4[8*m_win +: 8];
               m_grant = m_win;
               m_last = m_win;
               m_nb[2'(m_win)] = 1'b0;
            end else begin
               m_we = 1'b0;
            end
         end
         m_busy = m_nb;
         @(posedge clk);
         #1;
         check($sformatf("rand%0d", cyc), {we4, odata4, grant4, busy4},
               {m_we, m_data, 2'(m_grant), m_busy});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
